// File: rtl/score_pkg.sv
// Shared types and defaults for the score counter family.
package score_pkg;

  typedef enum logic {CNT_SATURATE, CNT_WRAP} cnt_mode_e;

  localparam int SCORE_W_DEFAULT = 4;

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector: the history bit is registered, so the pulse appears
// in the same cycle as the input's rising edge.
module rise_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/updown_score_counter.sv
// Parametrised up/down score counter with step, wrap/saturate modes,
// optional edge qualification, synchronous load and a sticky done flag.
module updown_score_counter
  import score_pkg::*;
#(
  parameter int        WIDTH       = SCORE_W_DEFAULT,
  parameter int        MAX_COUNT   = 9,
  parameter int        STEP_W      = 2,
  parameter cnt_mode_e MODE        = CNT_SATURATE,
  parameter int        EDGE_DET    = 1,
  parameter int        STICKY_DONE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stop_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              at_max_o,
  output logic              at_min_o,
  output logic              done_o,
  output logic              wrapped_o
);

  // One spare bit above the wider of count/step so sums never truncate.
  localparam int            CW       = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_COUNT);
  localparam logic [CW-1:0] M1       = CW'(MAX_COUNT + 1);
  localparam bit            WRAP     = (MODE == CNT_WRAP);
  localparam bit            SAT_DONE = (STICKY_DONE != 0) && !WRAP;

  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;
  logic             inc_ev, dec_ev;
  logic [CW-1:0]    step_c, out_c, sum_c, rem_c;

  generate
    if (EDGE_DET != 0) begin : g_edge
      rise_pulse u_inc_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (inc_i),
        .pulse_o (inc_ev)
      );
      rise_pulse u_dec_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (dec_i),
        .pulse_o (dec_ev)
      );
    end else begin : g_level
      assign inc_ev = inc_i;
      assign dec_ev = dec_i;
    end
  endgenerate

  always_comb begin
    step_c    = (step_i == '0) ? CW'(1) : CW'(step_i);
    out_c     = CW'(out_q);
    sum_c     = out_c + step_c;
    rem_c     = (step_c - out_c) % M1;
    out_d     = out_q;
    done_d    = done_q;
    wrapped_d = 1'b0;

    if (load_i) begin
      out_d  = (CW'(load_val_i) > MAX_C) ? WIDTH'(MAX_C) : load_val_i;
      done_d = 1'b0;
    end else if (!(stop_i || done_q) && (inc_ev != dec_ev)) begin
      if (inc_ev) begin
        if (WRAP) begin
          if (sum_c > MAX_C) begin
            out_d     = WIDTH'(sum_c % M1);
            wrapped_d = 1'b1;
          end else begin
            out_d = WIDTH'(sum_c);
          end
        end else if (sum_c >= MAX_C) begin
          out_d = WIDTH'(MAX_C);
          if (SAT_DONE) begin
            done_d = 1'b1;
          end
        end else begin
          out_d = WIDTH'(sum_c);
        end
      end else begin
        if (out_c < step_c) begin
          // Below zero: fold the deficit back from the top of the range.
          if (WRAP) begin
            out_d     = (rem_c == '0) ? '0 : WIDTH'(M1 - rem_c);
            wrapped_d = 1'b1;
          end else begin
            out_d = '0;
          end
        end else begin
          out_d = WIDTH'(out_c - step_c);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q     <= '0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign out_o     = out_q;
  assign at_max_o  = (out_q == WIDTH'(MAX_COUNT));
  assign at_min_o  = (out_q == '0);
  assign done_o    = done_q;
  assign wrapped_o = wrapped_q;

endmodule

// File: tb/tb_updown_score_counter.sv
// Bench: three counter flavours on shared stimulus, checked every cycle
// against an arithmetic model, plus hand-computed scenario checkpoints.
module tb_updown_score_counter;
  import score_pkg::*;

  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       rst, stop, inc, dec, load;
  logic [1:0] step;
  logic [3:0] load_val;

  logic [3:0] dout [3];
  logic       dmax [3];
  logic       dmin [3];
  logic       ddone [3];
  logic       dwr [3];

  // Model state, indexed by instance: 0 sat/edge/sticky, 1 wrap/edge, 2 sat/level
  int m_out [3];
  int m_done [3];
  int m_wr [3];
  int m_pi [3];
  int m_pd [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  updown_score_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .STEP_W(2), .MODE(CNT_SATURATE),
                         .EDGE_DET(1), .STICKY_DONE(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .stop_i(stop), .inc_i(inc), .dec_i(dec), .step_i(step),
    .load_i(load), .load_val_i(load_val), .out_o(dout[0]), .at_max_o(dmax[0]),
    .at_min_o(dmin[0]), .done_o(ddone[0]), .wrapped_o(dwr[0]));

  updown_score_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .STEP_W(2), .MODE(CNT_WRAP),
                         .EDGE_DET(1), .STICKY_DONE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .stop_i(stop), .inc_i(inc), .dec_i(dec), .step_i(step),
    .load_i(load), .load_val_i(load_val), .out_o(dout[1]), .at_max_o(dmax[1]),
    .at_min_o(dmin[1]), .done_o(ddone[1]), .wrapped_o(dwr[1]));

  updown_score_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .STEP_W(2), .MODE(CNT_SATURATE),
                         .EDGE_DET(0), .STICKY_DONE(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .stop_i(stop), .inc_i(inc), .dec_i(dec), .step_i(step),
    .load_i(load), .load_val_i(load_val), .out_o(dout[2]), .at_max_o(dmax[2]),
    .at_min_o(dmin[2]), .done_o(ddone[2]), .wrapped_o(dwr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next state from the rules: clamp, modulo and min/max on plain integers.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s, o, iev, dev;
      if (rst) begin
        m_out[k] = 0; m_done[k] = 0; m_wr[k] = 0; m_pi[k] = 0; m_pd[k] = 0;
        continue;
      end
      if (k != 2) begin
        iev = (inc && m_pi[k] == 0) ? 1 : 0;
        dev = (dec && m_pd[k] == 0) ? 1 : 0;
      end else begin
        iev = inc ? 1 : 0;
        dev = dec ? 1 : 0;
      end
      m_pi[k] = inc ? 1 : 0;
      m_pd[k] = dec ? 1 : 0;
      m_wr[k] = 0;
      s = (step == 0) ? 1 : int'(step);
      o = m_out[k];
      if (load) begin
        m_out[k]  = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
        m_done[k] = 0;
      end else if (stop || m_done[k] != 0) begin
        m_out[k] = o;
      end else if (iev == 1 && dev == 0) begin
        if (k == 1) begin
          m_wr[k]  = (o + s > MAXC) ? 1 : 0;
          m_out[k] = (o + s) % (MAXC + 1);
        end else begin
          m_out[k] = (o + s > MAXC) ? MAXC : o + s;
          if (k == 0 && m_out[k] == MAXC) m_done[k] = 1;
        end
      end else if (dev == 1 && iev == 0) begin
        if (k == 1) begin
          m_wr[k]  = (o < s) ? 1 : 0;
          m_out[k] = ((o - s) % (MAXC + 1) + MAXC + 1) % (MAXC + 1);
        end else begin
          m_out[k] = (o < s) ? 0 : o - s;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("out[%0d]", k), 32'(dout[k]), 32'(m_out[k]));
        check($sformatf("at_max[%0d]", k), 32'(dmax[k]), (m_out[k] == MAXC) ? 32'd1 : 32'd0);
        check($sformatf("at_min[%0d]", k), 32'(dmin[k]), (m_out[k] == 0) ? 32'd1 : 32'd0);
        check($sformatf("done[%0d]", k), 32'(ddone[k]), 32'(m_done[k]));
        check($sformatf("wrapped[%0d]", k), 32'(dwr[k]), 32'(m_wr[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_inc();
    inc = 1'b1; tick();
    inc = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
    step = 2'd1; load_val = 4'd0;
    #1;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_out", 32'(dout[0]), 32'd0);
    check("reset_done", 32'(ddone[0]), 32'd0);

    // Saturate to 9, then extra incs and a dec
    for (int i = 1; i <= 12; i++) begin
      pulse_inc();
      if (i <= 9) check($sformatf("t1_step%0d", i), 32'(dout[0]), 32'(i));
    end
    check("t1_done", 32'(ddone[0]), 32'd1);
    dec = 1'b1; tick(); dec = 1'b0; tick();
    check("t1_frozen", 32'(dout[0]), 32'd9);
    check("t1_model_frozen", 32'(m_out[0]), 32'd9);
    check("t1_wrap_inst", 32'(dout[1]), 32'd1);
    check("t1_nosticky_inst", 32'(dout[2]), 32'd8);

    // Wrap arithmetic from 8
    load = 1'b1; load_val = 4'd8; tick(); load = 1'b0;
    check("t2_load_done_clr", 32'(ddone[0]), 32'd0);
    step = 2'd3; inc = 1'b1; tick();
    check("t2_wrap_up_out", 32'(dout[1]), 32'd1);
    check("t2_wrap_up_flag", 32'(dwr[1]), 32'd1);
    check("t2_model_wrap_up", 32'(m_out[1]), 32'd1);
    inc = 1'b0; tick();
    check("t2_wrap_pulse_end", 32'(dwr[1]), 32'd0);
    step = 2'd2; dec = 1'b1; tick();
    check("t2_wrap_dn_out", 32'(dout[1]), 32'd9);
    check("t2_wrap_dn_flag", 32'(dwr[1]), 32'd1);
    dec = 1'b0; tick();

    // Held inc: edge vs level
    rst = 1'b1; tick(); rst = 1'b0; step = 2'd1;
    inc = 1'b1;
    repeat (5) tick();
    inc = 1'b0; tick();
    check("t3_edge_once", 32'(dout[0]), 32'd1);
    check("t3_level_five", 32'(dout[2]), 32'd5);

    // Cancel and stop
    inc = 1'b1; dec = 1'b1; tick();
    inc = 1'b0; dec = 1'b0; tick();
    check("t4_cancel_edge", 32'(dout[0]), 32'd1);
    check("t4_cancel_level", 32'(dout[2]), 32'd5);
    stop = 1'b1;
    repeat (3) pulse_inc();
    check("t4_stop_hold", 32'(dout[0]), 32'd1);
    stop = 1'b0;
    pulse_inc();
    check("t4_fresh_edge", 32'(dout[0]), 32'd2);
    stop = 1'b1; inc = 1'b1; tick();
    stop = 1'b0; tick();
    inc = 1'b0; tick();
    check("t4_no_edge_after_stop", 32'(dout[0]), 32'd2);

    // Load clamp and done recovery
    load = 1'b1; load_val = 4'd8; tick(); load = 1'b0;
    pulse_inc();
    check("t5_done_set", 32'(ddone[0]), 32'd1);
    load = 1'b1; load_val = 4'd15; tick();
    check("t5_clamp", 32'(dout[0]), 32'd9);
    check("t5_done_clr", 32'(ddone[0]), 32'd0);
    load_val = 4'd3; tick(); load = 1'b0;
    pulse_inc();
    check("t5_resume", 32'(dout[0]), 32'd4);

    // Reset with inc held high
    rst = 1'b1; tick(); rst = 1'b0;
    step = 2'd2;
    repeat (3) pulse_inc();
    check("t6_pre", 32'(dout[0]), 32'd6);
    step = 2'd1; inc = 1'b1; rst = 1'b1; tick();
    check("t6_rst_out", 32'(dout[0]), 32'd0);
    check("t6_rst_done", 32'(ddone[0]), 32'd0);
    rst = 1'b0; tick();
    check("t6_after_rel", 32'(dout[0]), 32'd1);
    tick();
    check("t6_once", 32'(dout[0]), 32'd1);
    inc = 1'b0; tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 7) == 0);
      inc      = 1'($urandom_range(0, 1));
      dec      = ($urandom_range(0, 2) == 0);
      step     = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
